cim_bitserial_mac_array: RTL and testbench
==========================================

Name: cim_bitserial_mac_array

Overview:
Next-generation multi-stack CIM compute tile with runtime-configurable weight precision and vector count. Weights arrive bit-serial, MSB first, as one bit-plane per stack per cycle. Each stack multiplies its weight by a double-buffered signed activation, accumulates across vectors, and scales the result by a per-operation signed factor. Results leave through a valid/ready output; backpressure stalls the weight stream.

Parameters:
NUM_STACKS, 8, number of parallel stacks
ACT_WIDTH, 8, signed activation width
WT_MAX_BITS, 8, maximum weight precision (two's complement)
MAX_VEC, 16, maximum vectors accumulated per operation (power of 2)
SCALE_WIDTH, 4, signed scale factor width
ACC_WIDTH, ACT_WIDTH+WT_MAX_BITS+$clog2(MAX_VEC), accumulator width (derived)
OUT_WIDTH, ACC_WIDTH+SCALE_WIDTH, output width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin operation (honoured only in IDLE)
cfg_wt_bits  in  $clog2(WT_MAX_BITS+1)  weight precision, legal 1..WT_MAX_BITS
cfg_num_vec  in  $clog2(MAX_VEC+1)  vectors per operation, legal 1..MAX_VEC
cfg_scale  in  SCALE_WIDTH  signed scale, latched at start
cfg_err  out  1  one-cycle pulse: start with illegal cfg
act_we  in  1  write staging activations
act_data  in  NUM_STACKS*ACT_WIDTH  signed activations, one per stack
wt_valid  in  1  weight bit-plane valid
wt_ready  out  1  weight bit-plane accepted when high with wt_valid
wt_bit  in  NUM_STACKS  one weight bit per stack
busy  out  1  high in any state except IDLE
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  NUM_STACKS*OUT_WIDTH  signed scaled results
done  out  1  one-cycle pulse on output handshake

Behaviour:
- Reset: state=IDLE. All outputs 0. act_stage, act_q, accumulators, partials and counters cleared.
- act_we writes act_stage in any state. act_q loads act_stage on the first accepted bit (bit_cnt==0) of each vector, so act_stage may be rewritten mid-vector for the next vector.
- IDLE:
  - start with legal cfg: latch cfg, clear acc/partial/bit_cnt/vec_cnt, go to RUN.
  - start with illegal cfg (wt_bits 0 or >WT_MAX_BITS, num_vec 0 or >MAX_VEC): cfg_err=1 for one cycle, stay in IDLE.
- RUN: wt_ready=1. On each beat, per stack, using act_sel = (bit_cnt==0 ? act_stage : act_q):
  - first bit (sign): partial = b ? -act_sel : 0
  - later bits: partial = 2*partial + (b ? act_sel : 0)
  - After bit wt_bits-1: acc += final partial (full signed sign-extension); bit_cnt=0; vec_cnt++.
  - If it was the last vector: go to SCALE.
  - No beat means all state holds (bubbles allowed).
- SCALE: one cycle; out_data_reg = acc * scale (signed); go to OUT.
- OUT: out_valid=1; out_data stable; wt_ready=0. On out_ready: done pulse, out_valid drops next cycle, return to IDLE.
- start outside IDLE is ignored (no cfg_err).
- Latency: last accepted weight beat to out_valid = 2 cycles.
- wt_bits=1 gives weights in {0,-1}.
- Widths cover the worst case: (-2^(A-1))*(-2^(W-1))*MAX_VEC*(-2^(S-1)). No overflow is possible.
- Reset mid-operation: reset dominates; return to IDLE with everything cleared.

Optional Feature:
CIM_RELU_EN:
- Defined: in SCALE, any negative scaled result is written as 0 (per stack).
- Undefined: the signed result is passed unmodified.

Test Plan:
- Basic multiply: stack0 act=5, wt_bits=4, bits 1,1,0,1 (w=-3), num_vec=1, scale=2. Expect out_data[0]=-30, out_valid 2 cycles after the last beat, done on handshake.
- Two-vector accumulate: vec0 act=3, w=0010; act_we during vec0 loads -4; vec1 w=0111; scale=1. Expect stack0=-22, proving double buffering.
- Backpressure and bubbles: insert wt_valid gaps, then hold out_ready=0 for 5 cycles. Expect the result unchanged by bubbles, out_valid and out_data stable, wt_ready=0, done only on the ready cycle.
- Extremes: act=-128, w=-128 (8 bits), num_vec=16, scale=-8. Expect -2097152 on all 8 stacks with no wrap.
- Config and reset: start with cfg_wt_bits=0, expect a cfg_err pulse and busy=0. Then a legal start, assert reset after 3 beats: expect IDLE with all outputs 0, and a following op gives the correct result.
- CIM_RELU_EN: the basic-multiply case yields 0 with the macro defined and -30 without it.

Source files
------------

// File: rtl/cim_bitserial_mac_array.sv
// Multi-stack bit-serial CIM MAC tile: MSB-first weights, double-buffered activations, scaled output.
// Optional macro CIM_RELU_EN clamps negative scaled results to zero.
module cim_bitserial_mac_array #(
  parameter int NUM_STACKS  = 8,
  parameter int ACT_WIDTH   = 8,
  parameter int WT_MAX_BITS = 8,
  parameter int MAX_VEC     = 16,
  parameter int SCALE_WIDTH = 4,
  parameter int ACC_WIDTH   = ACT_WIDTH + WT_MAX_BITS + $clog2(MAX_VEC),
  parameter int OUT_WIDTH   = ACC_WIDTH + SCALE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(WT_MAX_BITS+1)-1:0]     cfg_wt_bits,
  input  logic [$clog2(MAX_VEC+1)-1:0]         cfg_num_vec,
  input  logic [SCALE_WIDTH-1:0]               cfg_scale,
  output logic                                 cfg_err,
  input  logic                                 act_we,
  input  logic [NUM_STACKS*ACT_WIDTH-1:0]      act_data,
  input  logic                                 wt_valid,
  output logic                                 wt_ready,
  input  logic [NUM_STACKS-1:0]                wt_bit,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_STACKS*OUT_WIDTH-1:0]      out_data,
  output logic                                 done
);

  localparam int PW = ACT_WIDTH + WT_MAX_BITS;
  localparam int CW = $clog2(WT_MAX_BITS+1);
  localparam int VW = $clog2(MAX_VEC+1);
  localparam logic [CW-1:0] WT_MAX_C  = CW'(WT_MAX_BITS);
  localparam logic [VW-1:0] VEC_MAX_C = VW'(MAX_VEC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                        state_q, state_d;
  logic [CW-1:0]                     wt_bits_q, wt_bits_d, bit_cnt_q, bit_cnt_d;
  logic [VW-1:0]                     num_vec_q, num_vec_d, vec_cnt_q, vec_cnt_d;
  logic signed [SCALE_WIDTH-1:0]     scale_q, scale_d;
  logic [NUM_STACKS*ACT_WIDTH-1:0]   act_stage_q, act_stage_d, act_q, act_d;
  logic signed [PW-1:0]              partial_q [NUM_STACKS];
  logic signed [PW-1:0]              partial_d [NUM_STACKS];
  logic signed [ACC_WIDTH-1:0]       acc_q [NUM_STACKS];
  logic signed [ACC_WIDTH-1:0]       acc_d [NUM_STACKS];
  logic [NUM_STACKS*OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                              cfg_err_q, cfg_err_d;

  logic                              cfg_legal_s, beat_s, first_bit_s, last_bit_s, last_vec_s;
  logic signed [ACT_WIDTH-1:0]       act_sel_s [NUM_STACKS];
  logic signed [PW-1:0]              act_ext_s [NUM_STACKS];
  logic signed [PW-1:0]              pnext_s   [NUM_STACKS];
  logic signed [OUT_WIDTH-1:0]       prod_s    [NUM_STACKS];

  assign cfg_legal_s = (cfg_wt_bits != {CW{1'b0}}) && (cfg_wt_bits <= WT_MAX_C) &&
                       (cfg_num_vec != {VW{1'b0}}) && (cfg_num_vec <= VEC_MAX_C);
  assign beat_s      = (state_q == S_RUN) && wt_valid;
  assign first_bit_s = (bit_cnt_q == {CW{1'b0}});
  assign last_bit_s  = (bit_cnt_q == (wt_bits_q - CW'(1)));
  assign last_vec_s  = (vec_cnt_q == (num_vec_q - VW'(1)));

  // Per-stack datapath: the sign bit reads the staging buffer directly, later bits the latched copy.
  always_comb begin
    for (int s = 0; s < NUM_STACKS; s++) begin
      act_sel_s[s] = first_bit_s ? act_stage_q[s*ACT_WIDTH +: ACT_WIDTH]
                                 : act_q[s*ACT_WIDTH +: ACT_WIDTH];
      act_ext_s[s] = PW'(act_sel_s[s]);
      if (first_bit_s) begin
        pnext_s[s] = wt_bit[s] ? -act_ext_s[s] : {PW{1'b0}};
      end else begin
        pnext_s[s] = (partial_q[s] <<< 1) + (wt_bit[s] ? act_ext_s[s] : {PW{1'b0}});
      end
      prod_s[s] = OUT_WIDTH'(acc_q[s]) * OUT_WIDTH'(scale_q);
`ifdef CIM_RELU_EN
      if (prod_s[s][OUT_WIDTH-1]) begin
        prod_s[s] = {OUT_WIDTH{1'b0}};
      end else begin
        prod_s[s] = prod_s[s];
      end
`endif
    end
  end

  // Control FSM and state updates.
  always_comb begin
    state_d     = state_q;
    wt_bits_d   = wt_bits_q;
    num_vec_d   = num_vec_q;
    scale_d     = scale_q;
    bit_cnt_d   = bit_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    act_d       = act_q;
    partial_d   = partial_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    cfg_err_d   = 1'b0;
    if (act_we) begin
      act_stage_d = act_data;
    end else begin
      act_stage_d = act_stage_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start && cfg_legal_s) begin
          wt_bits_d = cfg_wt_bits;
          num_vec_d = cfg_num_vec;
          scale_d   = cfg_scale;
          bit_cnt_d = {CW{1'b0}};
          vec_cnt_d = {VW{1'b0}};
          partial_d = '{default: {PW{1'b0}}};
          acc_d     = '{default: {ACC_WIDTH{1'b0}}};
          state_d   = S_RUN;
        end else begin
          cfg_err_d = start;
        end
      end
      S_RUN: begin
        if (beat_s) begin
          if (first_bit_s) begin
            act_d = act_stage_q;
          end else begin
            act_d = act_q;
          end
          partial_d = pnext_s;
          if (last_bit_s) begin
            for (int s = 0; s < NUM_STACKS; s++) begin
              acc_d[s] = acc_q[s] + ACC_WIDTH'(pnext_s[s]);
            end
            bit_cnt_d = {CW{1'b0}};
            vec_cnt_d = vec_cnt_q + VW'(1);
            if (last_vec_s) begin
              state_d = S_SCALE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_SCALE: begin
        for (int s = 0; s < NUM_STACKS; s++) begin
          out_data_d[s*OUT_WIDTH +: OUT_WIDTH] = prod_s[s];
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wt_bits_q   <= {CW{1'b0}};
      num_vec_q   <= {VW{1'b0}};
      scale_q     <= {SCALE_WIDTH{1'b0}};
      bit_cnt_q   <= {CW{1'b0}};
      vec_cnt_q   <= {VW{1'b0}};
      act_stage_q <= {(NUM_STACKS*ACT_WIDTH){1'b0}};
      act_q       <= {(NUM_STACKS*ACT_WIDTH){1'b0}};
      partial_q   <= '{default: {PW{1'b0}}};
      acc_q       <= '{default: {ACC_WIDTH{1'b0}}};
      out_data_q  <= {(NUM_STACKS*OUT_WIDTH){1'b0}};
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wt_bits_q   <= wt_bits_d;
      num_vec_q   <= num_vec_d;
      scale_q     <= scale_d;
      bit_cnt_q   <= bit_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      act_stage_q <= act_stage_d;
      act_q       <= act_d;
      partial_q   <= partial_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != S_IDLE);
  assign wt_ready  = (state_q == S_RUN);
  assign out_valid = (state_q == S_OUT);
  assign done      = (state_q == S_OUT) && out_ready;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_cim_bitserial_mac_array.sv
// Scoreboard bench for cim_bitserial_mac_array: expected results are modelled as plain
// signed arithmetic when an operation is driven and compared at the output handshake.
module tb_cim_bitserial_mac_array;

  localparam int NS = 8;
  localparam int A  = 8;
  localparam int WM = 8;
  localparam int MV = 16;
  localparam int SW = 4;
  localparam int OW = A + WM + $clog2(MV) + SW;
  localparam int CW = $clog2(WM+1);
  localparam int VW = $clog2(MV+1);

  logic              clk;
  logic              reset;
  logic              start;
  logic [CW-1:0]     cfg_wt_bits;
  logic [VW-1:0]     cfg_num_vec;
  logic [SW-1:0]     cfg_scale;
  logic              cfg_err;
  logic              act_we;
  logic [NS*A-1:0]   act_data;
  logic              wt_valid;
  logic              wt_ready;
  logic [NS-1:0]     wt_bit;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [NS*OW-1:0]  out_data;
  logic              done;

  cim_bitserial_mac_array dut (
    .clk(clk), .reset(reset), .start(start), .cfg_wt_bits(cfg_wt_bits),
    .cfg_num_vec(cfg_num_vec), .cfg_scale(cfg_scale), .cfg_err(cfg_err),
    .act_we(act_we), .act_data(act_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .wt_bit(wt_bit), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [NS*OW-1:0] exp_q [$];
  int acts [MV][NS];
  int wts  [MV][NS];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint stack_out(input int s);
    return longint'($signed(out_data[s*OW +: OW]));
  endfunction

  task automatic drive_act(input int v);
    for (int s = 0; s < NS; s++) act_data[s*A +: A] = acts[v][s][A-1:0];
  endtask

  task automatic fill_rand(input int nb);
    for (int v = 0; v < MV; v++)
      for (int s = 0; s < NS; s++) begin
        acts[v][s] = int'($urandom_range(0, 255)) - 128;
        wts[v][s]  = int'($urandom_range(0, (1 << nb) - 1)) - (1 << (nb - 1));
      end
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_out_valid"}, longint'(out_valid), 0);
    check_val({tag, "_busy"}, longint'(busy), 0);
    check_val({tag, "_wt_ready"}, longint'(wt_ready), 0);
    check_val({tag, "_done"}, longint'(done), 0);
    check_val({tag, "_cfg_err"}, longint'(cfg_err), 0);
    check_val({tag, "_out_data_nz"}, longint'(out_data != '0), 0);
  endtask

  task automatic cfg_bad(input int nb, input int nv, input string tag);
    @(negedge clk);
    start = 1'b1; cfg_wt_bits = CW'(nb); cfg_num_vec = VW'(nv); cfg_scale = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_cfg_err"}, longint'(cfg_err), 1);
    check_val({tag, "_busy"}, longint'(busy), 0);
    @(negedge clk);
    check_val({tag, "_cfg_err_pulse"}, longint'(cfg_err), 0);
  endtask

  task automatic run_op(input int nb, input int nv, input int sc, input bit gaps, input int stall);
    logic [NS*OW-1:0] e;
    longint sum;
    for (int s = 0; s < NS; s++) begin
      sum = 0;
      for (int v = 0; v < nv; v++) sum += longint'(acts[v][s]) * longint'(wts[v][s]);
      sum = sum * sc;
`ifdef CIM_RELU_EN
      if (sum < 0) sum = 0;
`endif
      e[s*OW +: OW] = sum[OW-1:0];
    end
    exp_q.push_back(e);

    @(negedge clk);
    act_we = 1'b1; drive_act(0);
    @(negedge clk);
    act_we = 1'b0; start = 1'b1;
    cfg_wt_bits = CW'(nb); cfg_num_vec = VW'(nv); cfg_scale = sc[SW-1:0];
    @(negedge clk);
    start = 1'b0;
    check_val("run_busy", longint'(busy), 1);

    for (int v = 0; v < nv; v++) begin
      for (int i = 0; i < nb; i++) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          wt_valid = 1'b0; wt_bit = NS'($urandom);
          @(negedge clk);
        end
        check_val("beat_wt_ready", longint'(wt_ready), 1);
        wt_valid = 1'b1;
        for (int s = 0; s < NS; s++) wt_bit[s] = (wts[v][s] >> (nb - 1 - i)) & 1;
        if (i == 0 && v + 1 < nv) begin
          act_we = 1'b1; drive_act(v + 1);
        end
        @(negedge clk);
        wt_valid = 1'b0; act_we = 1'b0;
      end
    end

    check_val("lat1_out_valid", longint'(out_valid), 0);
    @(negedge clk);
    check_val("lat2_out_valid", longint'(out_valid), 1);

    for (int k = 0; k < stall; k++) begin
      check_val("stall_out_valid", longint'(out_valid), 1);
      check_val("stall_wt_ready", longint'(wt_ready), 0);
      check_val("stall_done", longint'(done), 0);
      check_val("stall_cfg_err", longint'(cfg_err), 0);
      check_val("stall_data_s0", stack_out(0), longint'($signed(exp_q[0][OW-1:0])));
      // An illegal start while busy must be ignored without raising cfg_err.
      start = (k == 0); cfg_wt_bits = '0;
      @(negedge clk);
      start = 1'b0;
    end

    out_ready = 1'b1;
    #1;
    check_val("hs_done", longint'(done), 1);
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      for (int s = 0; s < NS; s++)
        check_val($sformatf("out_s%0d", s), stack_out(s), longint'($signed(e[s*OW +: OW])));
    end
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_out_valid", longint'(out_valid), 0);
    check_val("post_busy", longint'(busy), 0);
    check_val("post_done", longint'(done), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_wt_bits = '0; cfg_num_vec = '0; cfg_scale = '0;
    act_we = 1'b0; act_data = '0; wt_valid = 1'b0; wt_bit = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // Basic multiply: 5 * (-3) * 2 on stack 0.
    fill_rand(4);
    acts[0][0] = 5; wts[0][0] = -3;
    run_op(4, 1, 2, 1'b0, 0);

    // Two vectors: 3*2 + (-4)*7 = -22, second activation staged mid-vector.
    fill_rand(4);
    acts[0][0] = 3; wts[0][0] = 2; acts[1][0] = -4; wts[1][0] = 7;
    run_op(4, 2, 1, 1'b0, 0);

    // Bubbles plus output backpressure.
    fill_rand(6);
    run_op(6, 3, -5, 1'b1, 5);

    // Worst-case magnitude on every stack.
    for (int v = 0; v < MV; v++)
      for (int s = 0; s < NS; s++) begin
        acts[v][s] = -128; wts[v][s] = -128;
      end
    run_op(8, 16, -8, 1'b0, 0);

    cfg_bad(0, 1, "bits0");
    cfg_bad(9, 1, "bits9");
    cfg_bad(4, 0, "vec0");
    cfg_bad(4, 17, "vec17");

    // Reset in the middle of an operation.
    fill_rand(4);
    @(negedge clk);
    act_we = 1'b1; drive_act(0);
    @(negedge clk);
    act_we = 1'b0; start = 1'b1; cfg_wt_bits = 4'd4; cfg_num_vec = 5'd1; cfg_scale = 4'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wt_valid = 1'b1; wt_bit = NS'($urandom);
      @(negedge clk);
    end
    wt_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("midreset");

    fill_rand(4);
    acts[0][0] = 5; wts[0][0] = -3;
    run_op(4, 1, 2, 1'b0, 0);

    fill_rand(1);
    run_op(1, 4, 3, 1'b1, 0);

    fill_rand(8);
    run_op(8, 16, 7, 1'b1, 2);

    check_val("sb_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
